// File: rtl/tmec_correct_buffer.sv
// Output-side data buffer for TMEC decode: stores the K data bits of each codeword
// and XORs them with Chien error flags on readout. Optional macro: BCH_CORRECT_ERRCNT_EN.
module tmec_correct_buffer #(
  parameter int unsigned N     = 15,
  parameter int unsigned K     = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din_valid,
  input  logic                     din_start,
  input  logic                     din,
  input  logic                     err_valid,
  input  logic                     err,
  output logic                     dout_valid,
  output logic                     dout,
  output logic                     dout_first,
  output logic                     dout_last,
  output logic [$clog2(K+1)-1:0]   err_count,
  output logic                     err_count_valid,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     framing_err
);

  localparam int unsigned MW = DEPTH * K;
  localparam int unsigned AW = $clog2(MW);
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned RW = $clog2(K);
  localparam int unsigned VW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_PARITY = 2'd2,
    S_DROP   = 2'd3
  } wstate_t;

  wstate_t         state;
  logic [PW-1:0]   wpos;
  logic [AW-1:0]   wbase;
  logic [AW-1:0]   rbase;
  logic [RW-1:0]   rpos;
  logic [VW-1:0]   words_avail;
  logic            mem [MW];

  logic            rd_fire;
  logic            rel;
  logic            start;
  logic            accept;
  logic            fill_wr;
  logic            commit;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [AW-1:0]   rd_addr;
  logic [VW-1:0]   avail_after;
  logic [AW-1:0]   wbase_nxt;
  logic [AW-1:0]   rbase_nxt;

  // Handshake decode; the accept test sees a same-cycle release so a full buffer can take a start as it drains.
  always_comb begin
    rd_fire     = err_valid && (words_avail != '0);
    rel         = rd_fire && (rpos == RW'(K - 1));
    avail_after = words_avail - VW'(rel);
    start       = din_valid && din_start;
    accept      = start && (avail_after < VW'(DEPTH));
    fill_wr     = din_valid && !din_start && (state == S_FILL);
    commit      = fill_wr && (wpos == PW'(K - 1));
    mem_we      = accept || fill_wr;
    mem_wa      = accept ? wbase : AW'(wbase + AW'(wpos));
    rd_addr     = AW'(rbase + AW'(rpos));
    wbase_nxt   = (wbase == AW'((DEPTH - 1) * K)) ? '0 : AW'(wbase + AW'(K));
    rbase_nxt   = (rbase == AW'((DEPTH - 1) * K)) ? '0 : AW'(rbase + AW'(K));
  end

  // Storage is deliberately not reset; words_avail gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= din;
  end

  // Write FSM, read pointer, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wpos        <= '0;
      wbase       <= '0;
      rbase       <= '0;
      rpos        <= '0;
      words_avail <= '0;
      dout_valid  <= 1'b0;
      dout        <= 1'b0;
      dout_first  <= 1'b0;
      dout_last   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (start) begin
        // A start while busy abandons the uncommitted bits; wbase is untouched.
        if (state != S_IDLE) framing_err <= 1'b1;
        wpos <= PW'(1);
        if (accept) begin
          state <= S_FILL;
        end else begin
          overflow <= 1'b1;
          state    <= S_DROP;
        end
      end else if (din_valid) begin
        case (state)
          S_FILL: begin
            wpos <= PW'(wpos + PW'(1));
            if (wpos == PW'(K - 1)) begin
              state <= S_PARITY;
              wbase <= wbase_nxt;
            end
          end
          S_PARITY, S_DROP: begin
            if (wpos == PW'(N - 1)) begin
              state <= S_IDLE;
              wpos  <= '0;
            end else begin
              wpos <= PW'(wpos + PW'(1));
            end
          end
          default: ;
        endcase
      end

      case ({commit, rel})
        2'b10:   words_avail <= VW'(words_avail + VW'(1));
        2'b01:   words_avail <= VW'(words_avail - VW'(1));
        default: ;
      endcase

      dout_valid <= rd_fire;
      dout_first <= rd_fire && (rpos == '0);
      dout_last  <= rel;
      if (rd_fire) begin
        dout <= mem[rd_addr] ^ err;
        if (rel) begin
          rpos  <= '0;
          rbase <= rbase_nxt;
        end else begin
          rpos <= RW'(rpos + RW'(1));
        end
      end
      if (err_valid && (words_avail == '0)) underflow <= 1'b1;
    end
  end

`ifdef BCH_CORRECT_ERRCNT_EN
  logic [CW-1:0] cnt;

  // Per-word flip counter, reported and cleared on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      err_count       <= '0;
      err_count_valid <= 1'b0;
    end else begin
      err_count_valid <= rel;
      if (rd_fire) begin
        if (rel) begin
          err_count <= CW'(cnt + CW'(err));
          cnt       <= '0;
        end else begin
          cnt <= CW'(cnt + CW'(err));
        end
      end
    end
  end
`else
  assign err_count       = '0;
  assign err_count_valid = 1'b0;
`endif

endmodule
